// File: rtl/wb_b3_burst_master.sv
// Wishbone B3 burst master.
// Turns single-word and cache-line client requests into classic (CTI 000) or
// incrementing/wrapping registered-feedback bursts. The per-beat address
// follows the slave's internal burst counter, so the slave never sees a
// burst-address mismatch.
module wb_b3_burst_master #(
  parameter int dw = 32,
  parameter int aw = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  // client request
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [aw-1:0] req_adr_i,
  input  logic [1:0]    req_len_i,
  input  logic          req_wrap_i,
  // client write beats
  input  logic [dw-1:0] wdat_i,
  input  logic [3:0]    wsel_i,
  output logic          wdat_rd_o,
  // client read beats / completion
  output logic [dw-1:0] rdat_o,
  output logic          rdat_valid_o,
  output logic          done_o,
  output logic          err_o,
  // Wishbone master port
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i
);

  typedef enum logic [1:0] {IDLE, XFER, FINISH} state_t;

  state_t        state_q, state_d;
  logic          we_q, wrap_q, err_q, rvld_q;
  logic [1:0]    len_q;
  logic [3:0]    cnt_q;
  logic [2:0]    cti_q;
  logic [aw-1:0] adr_q;
  logic [dw-1:0] rdat_q;

  logic          accept, beat_ok, bus_err;
  logic [aw-1:0] adr_lin, adr_wrap;
  logic [3:0]    widx, winc, wmask;

  // Low address bits are dropped: the bus is word addressed.
  logic unused_adr_lo;
  assign unused_adr_lo = ^req_adr_i[1:0];

  assign accept  = (state_q == IDLE) & req_valid_i & wb_rst_i;
  // An error or retry beside an ack wins: that beat is neither delivered nor counted.
  assign beat_ok = (state_q == XFER) & wb_ack_i & ~wb_err_i & ~wb_rty_i;
  assign bus_err = (state_q == XFER) & (wb_err_i | wb_rty_i);

  // Next beat address: linear is a full-width +4; wrapping only cycles the
  // word index inside the 4/8/16-word window and leaves upper bits alone.
  assign adr_lin  = adr_q + aw'(4);
  assign widx     = adr_q[5:2];
  assign winc     = widx + 4'd1;
  assign wmask    = (len_q == 2'b11) ? 4'hf : (len_q == 2'b10) ? 4'h7 : 4'h3;
  assign adr_wrap = {adr_q[aw-1:6], (winc & wmask) | (widx & ~wmask), 2'b00};

  assign wb_adr_o     = adr_q;
  assign rdat_o       = rdat_q;
  assign rdat_valid_o = rvld_q;

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state and bus/client outputs; everything idles low outside XFER.
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    wdat_rd_o   = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    wb_cyc_o    = 1'b0;
    wb_stb_o    = 1'b0;
    wb_we_o     = 1'b0;
    wb_sel_o    = 4'h0;
    wb_dat_o    = '0;
    wb_cti_o    = 3'b000;
    wb_bte_o    = 2'b00;
    case (state_q)
      IDLE: begin
        // Held low while reset is asserted so every output reads 0 in reset.
        req_ready_o = wb_rst_i;
        if (accept) state_d = XFER;
      end
      XFER: begin
        wb_cyc_o  = 1'b1;
        wb_stb_o  = 1'b1;
        wb_we_o   = we_q;
        wb_sel_o  = we_q ? wsel_i : 4'hf;
        wb_dat_o  = we_q ? wdat_i : '0;
        wb_cti_o  = cti_q;
        wb_bte_o  = wrap_q ? len_q : 2'b00;
        wdat_rd_o = we_q & beat_ok;
        if (bus_err || (beat_ok && cnt_q == 4'd0)) state_d = FINISH;
      end
      FINISH: begin
        done_o  = 1'b1;
        err_o   = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, beat counter, address/CTI advance and read-data capture.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      we_q   <= 1'b0;
      wrap_q <= 1'b0;
      len_q  <= 2'b00;
      cnt_q  <= 4'd0;
      cti_q  <= 3'b000;
      adr_q  <= '0;
      err_q  <= 1'b0;
      rdat_q <= '0;
      rvld_q <= 1'b0;
    end else begin
      rvld_q <= 1'b0;
      if (accept) begin
        we_q   <= req_we_i;
        len_q  <= req_len_i;
        wrap_q <= req_wrap_i & (req_len_i != 2'b00);
        adr_q  <= {req_adr_i[aw-1:2], 2'b00};
        err_q  <= 1'b0;
        case (req_len_i)
          2'b00:   cnt_q <= 4'd0;
          2'b01:   cnt_q <= 4'd3;
          2'b10:   cnt_q <= 4'd7;
          default: cnt_q <= 4'd15;
        endcase
        cti_q  <= (req_len_i == 2'b00) ? 3'b000 : 3'b010;
      end
      if (beat_ok) begin
        cnt_q <= cnt_q - 4'd1;
        adr_q <= wrap_q ? adr_wrap : adr_lin;
        if (len_q != 2'b00) cti_q <= (cnt_q == 4'd1) ? 3'b111 : 3'b010;
        if (!we_q) begin
          rdat_q <= wb_dat_i;
          rvld_q <= 1'b1;
        end
      end
      if (bus_err) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_b3_burst_master.sv
// Bench for wb_b3_burst_master: a RAM slave model (registered feedback,
// 256 KB, error above 0x3FFFF, optional stall) plus a scoreboard monitor.
module tb_wb_b3_burst_master;

  logic        wb_clk_i, wb_rst_i;
  logic        req_valid_i, req_ready_o, req_we_i, req_wrap_i;
  logic [31:0] req_adr_i;
  logic [1:0]  req_len_i;
  logic [31:0] wdat_i;
  logic [3:0]  wsel_i;
  logic        wdat_rd_o;
  logic [31:0] rdat_o;
  logic        rdat_valid_o, done_o, err_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        wb_ack_i, wb_err_i, wb_rty_i;

  wb_b3_burst_master dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_adr_i(req_adr_i), .req_len_i(req_len_i), .req_wrap_i(req_wrap_i),
    .wdat_i(wdat_i), .wsel_i(wsel_i), .wdat_rd_o(wdat_rd_o),
    .rdat_o(rdat_o), .rdat_valid_o(rdat_valid_o), .done_o(done_o), .err_o(err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  function automatic logic [31:0] iv(input int w);
    return 32'hC0DE_0000 ^ 32'(w);
  endfunction

  // ---------------- RAM slave model ----------------
  logic [31:0] mem [0:65535];
  bit          init_done;
  int          beats_done, stall_used;
  int          stall_beat, stall_len;

  assign wb_rty_i = 1'b0;
  assign wb_dat_i = (wb_cyc_o && wb_stb_o && wb_ack_i) ? mem[wb_adr_o[17:2]] : 32'h0;

  // Registered-feedback slave: ack one cycle after strobe, back-to-back
  // while CTI says the burst continues; error for addresses above 256 KB.
  always @(posedge wb_clk_i) begin
    if (!wb_rst_i && !init_done) begin
      for (int i = 0; i < 65536; i++) mem[i] <= iv(i);
      mem[16'h0041] <= 32'hDEADBEEF;
      init_done <= 1'b1;
    end
    if (!wb_rst_i || !wb_cyc_o) begin
      wb_ack_i <= 1'b0; wb_err_i <= 1'b0; beats_done <= 0; stall_used <= 0;
    end else begin
      if (wb_ack_i && wb_we_o)
        for (int b = 0; b < 4; b++)
          if (wb_sel_o[b]) mem[wb_adr_o[17:2]][8*b +: 8] <= wb_dat_o[8*b +: 8];
      if (wb_ack_i) beats_done <= beats_done + 1;
      if (!wb_stb_o || wb_err_i) begin
        wb_ack_i <= 1'b0; wb_err_i <= 1'b0;
      end else if (|wb_adr_o[31:18]) begin
        wb_ack_i <= 1'b0; wb_err_i <= 1'b1;
      end else if (wb_ack_i && (wb_cti_o == 3'b000 || wb_cti_o == 3'b111)) begin
        wb_ack_i <= 1'b0;
      end else if (stall_used < stall_len && beats_done + int'(wb_ack_i) == stall_beat) begin
        wb_ack_i <= 1'b0; stall_used <= stall_used + 1;
      end else begin
        wb_ack_i <= 1'b1;
      end
    end
  end

  // ---------------- write-beat source ----------------
  logic [31:0] wbuf  [0:15];
  logic [3:0]  wsbuf [0:15];
  int          wbeat, wbase;
  always @(posedge wb_clk_i) if (wdat_rd_o) wbeat <= wbeat + 1;
  assign wdat_i = wbuf[4'(wbeat - wbase)];
  assign wsel_i = wsbuf[4'(wbeat - wbase)];

  // ---------------- scoreboard ----------------
  typedef struct packed { logic [31:0] adr; logic [2:0] cti; logic [1:0] bte; } beat_t;
  beat_t       bq[$];
  logic [31:0] rq[$];
  bit          dq_err[$];
  int          dq_cyc[$];
  int          checks, failures, cycle;
  int          done_cnt, rvld_cnt, wrd_cnt;
  bit          mon_en, prev_stall;
  logic [31:0] prev_adr;
  logic [2:0]  prev_cti;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  always @(posedge wb_clk_i) cycle <= cycle + 1;

  // Monitor: pops expectations whenever the bus or client side shows an event.
  always @(negedge wb_clk_i) begin
    if (mon_en) begin
      if (wb_cyc_o && wb_stb_o && (wb_ack_i || wb_err_i)) begin
        if (bq.size() == 0) check("beat_unexpected", {32'h0, wb_adr_o}, 64'hFFFF_FFFF);
        else check("beat_adr_cti_bte", 64'({wb_adr_o, wb_cti_o, wb_bte_o}), 64'(bq.pop_front()));
      end
      if (wb_cyc_o && wb_stb_o && prev_stall)
        check("stall_hold", 64'({wb_adr_o, wb_cti_o}), 64'({prev_adr, prev_cti}));
      if (rdat_valid_o) begin
        if (rq.size() == 0) check("rdat_unexpected", 64'(rdat_o), 64'hFFFF_FFFF_FFFF);
        else check("rdat", 64'(rdat_o), 64'(rq.pop_front()));
      end
      if (done_o) begin
        if (dq_err.size() == 0) check("done_unexpected", 64'd1, 64'd0);
        else begin
          check("done_err", 64'(err_o), 64'(dq_err.pop_front()));
          check("done_cycle", 64'(cycle), 64'(dq_cyc.pop_front()));
        end
      end
    end
    prev_stall = wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i;
    prev_adr   = wb_adr_o;
    prev_cti   = wb_cti_o;
    if (rdat_valid_o) rvld_cnt++;
    if (wdat_rd_o)    wrd_cnt++;
    if (done_o)       done_cnt++;
  end

  task automatic push_beat(input logic [31:0] a, input logic [2:0] c, input logic [1:0] b);
    beat_t e;
    e.adr = a; e.cti = c; e.bte = b;
    bq.push_back(e);
  endtask

  // Issue one request, expect done at accept-cycle + lat, wait for it.
  task automatic run(input bit we, input logic [31:0] a, input logic [1:0] len,
                     input bit wrap, input int lat, input bit experr);
    int t, to;
    to = 0;
    while (!req_ready_o && to < 50) begin @(negedge wb_clk_i); to++; end
    req_we_i = we; req_adr_i = a; req_len_i = len; req_wrap_i = wrap; req_valid_i = 1'b1;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    req_valid_i = 1'b0;
    t = cycle;
    check("cyc_stb_after_accept", 64'({wb_cyc_o, wb_stb_o}), 64'd3);
    dq_err.push_back(experr);
    dq_cyc.push_back(t + lat);
    to = 0;
    while (!done_o && to < 100) begin @(negedge wb_clk_i); to++; end
    if (!done_o) check("done_timeout", 64'd0, 64'd1);
    @(negedge wb_clk_i);
    check("ready_after_done", 64'(req_ready_o), 64'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_ctl", 64'({req_ready_o, wdat_rd_o, rdat_valid_o, done_o, err_o, wb_we_o,
                          wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o, wb_sel_o}), 64'd0);
    check("rst_data", 64'(rdat_o | wb_adr_o | wb_dat_o), 64'd0);
  endtask

  logic [31:0] wrap4_adr [0:3];
  logic [31:0] wrap8_adr [0:7];

  initial begin
    int r0, w0, d0;
    wb_rst_i = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_adr_i = '0;
    req_len_i = '0; req_wrap_i = 1'b0;
    stall_beat = -1; stall_len = 0; wbeat = 0; wbase = 0; mon_en = 1'b1;
    for (int i = 0; i < 16; i++) begin wbuf[i] = 32'hA5A5_0000 + 32'(i * 32'h111); wsbuf[i] = 4'hf; end
    wsbuf[2] = 4'h3;
    wrap4_adr = '{32'h18, 32'h1C, 32'h10, 32'h14};
    wrap8_adr = '{32'h3C, 32'h20, 32'h24, 32'h28, 32'h2C, 32'h30, 32'h34, 32'h38};

    // Reset state
    repeat (3) @(negedge wb_clk_i);
    check_reset_outputs();
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    check("ready_after_reset", 64'(req_ready_o), 64'd1);

    // Single read, wrap flag must be ignored for 1-beat requests
    push_beat(32'h104, 3'b000, 2'b00);
    rq.push_back(32'hDEADBEEF);
    r0 = rvld_cnt;
    run(1'b0, 32'h0000_0106, 2'b00, 1'b1, 2, 1'b0);
    check("single_rvld_count", 64'(rvld_cnt - r0), 64'd1);

    // 4-beat wrapping read
    for (int i = 0; i < 4; i++) begin
      push_beat(wrap4_adr[i], (i == 3) ? 3'b111 : 3'b010, 2'b01);
      rq.push_back(iv(int'(wrap4_adr[i] >> 2)));
    end
    r0 = rvld_cnt;
    run(1'b0, 32'h0000_0018, 2'b01, 1'b1, 5, 1'b0);
    check("wrap4_rvld_count", 64'(rvld_cnt - r0), 64'd4);

    // 8-beat wrapping read starting at the top of its window
    for (int i = 0; i < 8; i++) begin
      push_beat(wrap8_adr[i], (i == 7) ? 3'b111 : 3'b010, 2'b10);
      rq.push_back(iv(int'(wrap8_adr[i] >> 2)));
    end
    run(1'b0, 32'h0000_003C, 2'b10, 1'b1, 9, 1'b0);

    // 8-beat linear write crossing 0x20000, beat 2 writes only bytes [15:0]
    for (int i = 0; i < 8; i++) push_beat(32'h1FFF0 + 32'(4 * i), (i == 7) ? 3'b111 : 3'b010, 2'b00);
    wbase = wbeat; w0 = wrd_cnt;
    run(1'b1, 32'h0001_FFF0, 2'b10, 1'b0, 9, 1'b0);
    check("write_wdat_rd_count", 64'(wrd_cnt - w0), 64'd8);

    // Read back the written lines
    for (int i = 0; i < 8; i++) begin
      push_beat(32'h1FFF0 + 32'(4 * i), (i == 7) ? 3'b111 : 3'b010, 2'b00);
      rq.push_back((i == 2) ? {16'hC0DE, wbuf[2][15:0]} : wbuf[i]);
    end
    run(1'b0, 32'h0001_FFF0, 2'b10, 1'b0, 9, 1'b0);

    // Out-of-range 16-beat read: error on the first response
    push_beat(32'h0004_0000, 3'b010, 2'b00);
    r0 = rvld_cnt;
    run(1'b0, 32'h0004_0000, 2'b11, 1'b0, 2, 1'b1);
    check("err_rvld_count", 64'(rvld_cnt - r0), 64'd0);

    // Stall on beat 1 of a 4-beat linear read
    stall_beat = 1; stall_len = 3;
    for (int i = 0; i < 4; i++) begin
      push_beat(32'h200 + 32'(4 * i), (i == 3) ? 3'b111 : 3'b010, 2'b00);
      rq.push_back(iv(32'h80 + i));
    end
    run(1'b0, 32'h0000_0200, 2'b01, 1'b0, 8, 1'b0);
    stall_len = 0;

    // Reset in the middle of a 16-beat read
    mon_en = 1'b0;
    d0 = done_cnt;
    req_we_i = 1'b0; req_adr_i = 32'h1000; req_len_i = 2'b11; req_wrap_i = 1'b0; req_valid_i = 1'b1;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    req_valid_i = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    check("midburst_cyc_before_reset", 64'(wb_cyc_o), 64'd1);
    wb_rst_i = 1'b0;
    repeat (3) begin @(negedge wb_clk_i); check_reset_outputs(); end
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    check("ready_after_midburst_reset", 64'(req_ready_o), 64'd1);
    repeat (3) @(negedge wb_clk_i);
    check("no_done_on_reset", 64'(done_cnt - d0), 64'd0);
    mon_en = 1'b1;

    // Recovery: single read after reset
    push_beat(32'h104, 3'b000, 2'b00);
    rq.push_back(32'hDEADBEEF);
    run(1'b0, 32'h0000_0104, 2'b00, 1'b0, 2, 1'b0);

    repeat (2) @(negedge wb_clk_i);
    check("beat_queue_drained", 64'(bq.size()), 64'd0);
    check("rdat_queue_drained", 64'(rq.size()), 64'd0);
    check("done_queue_drained", 64'(dq_err.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
